cp0_exc_unit: RTL

- Parametrised coprocessor-0 and exception-commit unit for the write-back stage of the five-stage MIPS pipeline.
- Implements Status, Cause, EPC, BadVAddr, Count and Compare.
- Prioritises the exception flags carried by the MEM->WB bus, takes hardware, timer and software interrupts, and drives the exception/eret redirect and cancel toward fetch.
- Replaces the fixed three-register syscall/eret-only CP0 logic in write-back.

---
 rtl/cp0_defs.sv | 42 ++++
 rtl/cp0_timer.sv | 73 +++++++
 rtl/cp0_exc_unit.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/cp0_defs.sv
// Shared definitions for the CP0 / exception-commit unit.
//   - CP0 register addresses as {rd[4:0], sel[2:0]}
//   - ExcCode values written into Cause
//   - Status/Cause bit positions, Status reset value and write mask
//   - cause_pack(): assembles the architectural Cause word
package cp0_defs;

  localparam logic [7:0] CP0_BADVADDR = {5'd8,  3'd0};
  localparam logic [7:0] CP0_COUNT    = {5'd9,  3'd0};
  localparam logic [7:0] CP0_COMPARE  = {5'd11, 3'd0};
  localparam logic [7:0] CP0_STATUS   = {5'd12, 3'd0};
  localparam logic [7:0] CP0_CAUSE    = {5'd13, 3'd0};
  localparam logic [7:0] CP0_EPC      = {5'd14, 3'd0};

  localparam logic [4:0] EXC_INT  = 5'h00;
  localparam logic [4:0] EXC_ADEL = 5'h04;
  localparam logic [4:0] EXC_ADES = 5'h05;
  localparam logic [4:0] EXC_SYS  = 5'h08;
  localparam logic [4:0] EXC_BP   = 5'h09;
  localparam logic [4:0] EXC_RI   = 5'h0A;
  localparam logic [4:0] EXC_OV   = 5'h0C;

  localparam int ST_IE     = 0;
  localparam int ST_EXL    = 1;
  localparam int ST_IM_LO  = 8;
  localparam int ST_BEV    = 22;
  localparam int CA_IP_LO  = 8;
  localparam int CA_TI     = 30;
  localparam int CA_BD     = 31;

  // BEV is hard-wired to 1; only IM, EXL and IE are software-writable.
  localparam logic [31:0] STATUS_RESET = 32'h0040_0000;
  localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;

  function automatic logic [31:0] cause_pack(input logic       bd,
                                             input logic       ti,
                                             input logic [7:0] ip,
                                             input logic [4:0] exc);
    return {bd, ti, 14'b0, ip, 1'b0, exc, 2'b00};
  endfunction

endpackage

// File: rtl/cp0_timer.sv
// Count/Compare timer for CP0.
//   clk_i, reset_i   : clock, synchronous active-high reset
//   count_we_i       : software write of Count (overrides increment, clears divider)
//   compare_we_i     : software write of Compare (clears TI)
//   wdata_i          : write data for either register
//   count_o          : current Count
//   compare_o        : current Compare
//   ti_o             : timer interrupt flag (Cause.TI)
module cp0_timer #(
  parameter int COUNT_DIV = 2
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        count_we_i,
  input  logic        compare_we_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] count_o,
  output logic [31:0] compare_o,
  output logic        ti_o
);

  localparam int DIV_W = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;

  logic [DIV_W-1:0] div_q, div_d;
  logic [31:0]      count_q, count_d;
  logic [31:0]      compare_q, compare_d;
  logic             ti_q, ti_d;
  logic             tick;
  logic [31:0]      count_inc;

  // With COUNT_DIV == 1 the divider sits at 0 and every cycle is a tick.
  assign tick      = (div_q == DIV_W'(COUNT_DIV - 1));
  assign count_inc = count_q + 32'd1;

  always_comb begin
    div_d     = tick ? '0 : div_q + DIV_W'(1);
    count_d   = count_q;
    compare_d = compare_q;
    ti_d      = ti_q;
    if (tick) count_d = count_inc;
    if (count_we_i) begin
      count_d = wdata_i;
      div_d   = '0;
    end
    // A Compare write clears TI; the match uses the new Compare only from
    // the next cycle on, so no set is evaluated in the write cycle.
    if (compare_we_i) begin
      compare_d = wdata_i;
      ti_d      = 1'b0;
    end else if (tick && !count_we_i && (count_inc == compare_q)) begin
      ti_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      div_q     <= '0;
      count_q   <= '0;
      compare_q <= '0;
      ti_q      <= 1'b0;
    end else begin
      div_q     <= div_d;
      count_q   <= count_d;
      compare_q <= compare_d;
      ti_q      <= ti_d;
    end
  end

  assign count_o   = count_q;
  assign compare_o = compare_q;
  assign ti_o      = ti_q;

endmodule

// File: rtl/cp0_exc_unit.sv
// CP0 register file and exception-commit logic for the write-back stage.
// Holds Status, Cause, EPC, BadVAddr (Count/Compare live in cp0_timer),
// prioritises the MEM->WB exception flags and pending interrupts, and
// drives the fetch redirect/cancel for exceptions and eret.
//   clk, reset            : clock, synchronous active-high reset
//   wb_valid              : valid instruction in WB
//   mtc0/mfc0, cp0_addr   : CP0 move, address {rd, sel}
//   wdata / rdata         : MTC0 data in / MFC0 data out (combinational)
//   exc_* , eret          : exception/eret flags from MEM->WB
//   pc, bad_vaddr         : WB PC and faulting data address
//   in_delay_slot         : WB instruction sits in a branch delay slot
//   hw_int                : level-sensitive hardware interrupts
//   exc_valid/exc_pc      : redirect request and target
//   cancel                : flush IF..MEM (same as exc_valid)
//   int_pending           : an enabled interrupt is pending
module cp0_exc_unit
  import cp0_defs::*;
#(
  parameter logic [31:0] EXC_ENTRY  = 32'hBFC0_0380,
  parameter int          NUM_HW_INT = 6,
  parameter int          COUNT_DIV  = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wb_valid,
  input  logic                  mtc0,
  input  logic                  mfc0,
  input  logic [7:0]            cp0_addr,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata,
  input  logic                  exc_fetch,
  input  logic                  exc_reserved,
  input  logic                  exc_ov,
  input  logic                  exc_syscall,
  input  logic                  exc_break,
  input  logic                  exc_raddr,
  input  logic                  exc_waddr,
  input  logic                  eret,
  input  logic [31:0]           pc,
  input  logic [31:0]           bad_vaddr,
  input  logic                  in_delay_slot,
  input  logic [NUM_HW_INT-1:0] hw_int,
  output logic                  exc_valid,
  output logic [31:0]           exc_pc,
  output logic                  cancel,
  output logic                  int_pending
);

  logic [31:0] status_q, status_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] badv_q, badv_d;
  logic        bd_q, bd_d;
  logic [4:0]  excode_q, excode_d;
  logic [1:0]  ip_sw_q, ip_sw_d;
  logic [5:0]  ip_hw_q, ip_hw_d;

  logic [31:0] count, compare;
  logic        ti;
  logic [7:0]  ip;
  logic [31:0] cause;

  logic        exc_any;
  logic [4:0]  exc_code;
  logic        badv_upd;
  logic [31:0] badv_src;
  logic        take_exc, take_eret, wr_en;

  // Unused high hw lines read as 0, so IP[7] collapses to TI alone.
  assign ip    = {ip_hw_q[5] | ti, ip_hw_q[4:0], ip_sw_q};
  assign cause = cause_pack(bd_q, ti, ip, excode_q);

  assign int_pending = status_q[ST_IE] & ~status_q[ST_EXL]
                     & |(ip & status_q[ST_IM_LO +: 8]);

  always_comb begin
    exc_any  = 1'b1;
    exc_code = EXC_INT;
    badv_upd = 1'b0;
    badv_src = bad_vaddr;
    if (int_pending)       exc_code = EXC_INT;
    else if (exc_fetch)    begin exc_code = EXC_ADEL; badv_upd = 1'b1; badv_src = pc; end
    else if (exc_reserved) exc_code = EXC_RI;
    else if (exc_ov)       exc_code = EXC_OV;
    else if (exc_syscall)  exc_code = EXC_SYS;
    else if (exc_break)    exc_code = EXC_BP;
    else if (exc_raddr)    begin exc_code = EXC_ADEL; badv_upd = 1'b1; end
    else if (exc_waddr)    begin exc_code = EXC_ADES; badv_upd = 1'b1; end
    else                   exc_any = 1'b0;
  end

  assign take_exc  = wb_valid & exc_any;
  assign take_eret = wb_valid & eret & ~exc_any;
  assign wr_en     = wb_valid & mtc0 & ~exc_any;

  assign exc_valid = wb_valid & (exc_any | eret);
  assign cancel    = exc_valid;
  assign exc_pc    = exc_any ? EXC_ENTRY : epc_q;

  always_comb begin
    status_d = status_q;
    epc_d    = epc_q;
    badv_d   = badv_q;
    bd_d     = bd_q;
    excode_d = excode_q;
    ip_sw_d  = ip_sw_q;
    ip_hw_d  = '0;
    ip_hw_d[NUM_HW_INT-1:0] = hw_int;
    if (wr_en) begin
      case (cp0_addr)
        CP0_STATUS: status_d = STATUS_RESET | (wdata & STATUS_WMASK);
        CP0_CAUSE:  ip_sw_d  = wdata[9:8];
        CP0_EPC:    epc_d    = wdata;
        default:    ;
      endcase
    end
    if (take_exc) begin
      excode_d = exc_code;
      // A nested exception keeps the EPC/BD of the outermost one.
      if (!status_q[ST_EXL]) begin
        epc_d = in_delay_slot ? pc - 32'd4 : pc;
        bd_d  = in_delay_slot;
      end
      status_d[ST_EXL] = 1'b1;
      if (badv_upd) badv_d = badv_src;
    end else if (take_eret) begin
      status_d[ST_EXL] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      status_q <= STATUS_RESET;
      epc_q    <= '0;
      badv_q   <= '0;
      bd_q     <= 1'b0;
      excode_q <= '0;
      ip_sw_q  <= '0;
      ip_hw_q  <= '0;
    end else begin
      status_q <= status_d;
      epc_q    <= epc_d;
      badv_q   <= badv_d;
      bd_q     <= bd_d;
      excode_q <= excode_d;
      ip_sw_q  <= ip_sw_d;
      ip_hw_q  <= ip_hw_d;
    end
  end

  cp0_timer #(
    .COUNT_DIV (COUNT_DIV)
  ) u_timer (
    .clk_i        (clk),
    .reset_i      (reset),
    .count_we_i   (wr_en && (cp0_addr == CP0_COUNT)),
    .compare_we_i (wr_en && (cp0_addr == CP0_COMPARE)),
    .wdata_i      (wdata),
    .count_o      (count),
    .compare_o    (compare),
    .ti_o         (ti)
  );

  always_comb begin
    rdata = '0;
    if (mfc0) begin
      case (cp0_addr)
        CP0_BADVADDR: rdata = badv_q;
        CP0_COUNT:    rdata = count;
        CP0_COMPARE:  rdata = compare;
        CP0_STATUS:   rdata = status_q;
        CP0_CAUSE:    rdata = cause;
        CP0_EPC:      rdata = epc_q;
        default:      rdata = '0;
      endcase
    end
  end

endmodule
